keypad_row_decoder: RTL and testbench

- Receiving end of the 4x4 keypad column scan.
- Samples the four row lines, synchronises and debounces them, and locks the column scanner on the active column through `key_pressed`.
- Emits one `key_valid` pulse with a 4-bit `key_code` per debounced press.
- Sits between the keypad row pins and the downstream key-buffer/display logic, clocked by the same 1 kHz `slow_clk` as the scanner.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/sync_2ff.sv | 23 ++
 rtl/keypad_row_decoder.sv | 125 ++++++++++++
 tb/tb_keypad_row_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key-code map for the 4x4 keypad datapath
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, DEBOUNCE, PRESSED} kp_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // key_code = row*4 + col on a standard telephone-style 4x4 pad
  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_2    = 4'h1;
  localparam logic [3:0] KEY_3    = 4'h2;
  localparam logic [3:0] KEY_A    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_B    = 4'h7;
  localparam logic [3:0] KEY_7    = 4'h8;
  localparam logic [3:0] KEY_8    = 4'h9;
  localparam logic [3:0] KEY_9    = 4'hA;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  function automatic logic [7:0] key_to_char(input logic [3:0] code);
    case (code)
      4'h0: key_to_char = "1";
      4'h1: key_to_char = "2";
      4'h2: key_to_char = "3";
      4'h3: key_to_char = "A";
      4'h4: key_to_char = "4";
      4'h5: key_to_char = "5";
      4'h6: key_to_char = "6";
      4'h7: key_to_char = "B";
      4'h8: key_to_char = "7";
      4'h9: key_to_char = "8";
      4'hA: key_to_char = "9";
      4'hB: key_to_char = "C";
      4'hC: key_to_char = "*";
      4'hD: key_to_char = "0";
      4'hE: key_to_char = "#";
      default: key_to_char = "D";
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterised two-flop synchroniser
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_row_decoder.sv
// rtl/keypad_row_decoder.sv - row sampling, column lock, press/release debounce and key strobe
module keypad_row_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                slow_clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  input  logic [1:0]          column_index,
  output logic                key_pressed,
  output logic [3:0]          key_code,
  output logic                key_valid
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  kp_state_t           state;
  logic [NUM_ROWS-1:0] row_s;
  logic [1:0]          col_d1, col_d2;
  logic [1:0]          cap_row, cap_col;
  logic [1:0]          row_idx;
  logic                any_row;
  logic                cap_level;
  logic [SW-1:0]       settle_cnt;
  logic [DW-1:0]       deb_cnt;
  logic [DW-1:0]       rel_cnt;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk (slow_clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  // Column delayed by the synchroniser depth so col_d2 names the column that drove row_s
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      col_d1 <= '0;
      col_d2 <= '0;
    end else begin
      col_d1 <= column_index;
      col_d2 <= col_d1;
    end
  end

  always_comb begin
    row_idx = 2'd0;
    if (row_s[0])      row_idx = 2'd0;
    else if (row_s[1]) row_idx = 2'd1;
    else if (row_s[2]) row_idx = 2'd2;
    else if (row_s[3]) row_idx = 2'd3;
  end

  assign any_row   = |row_s;
  assign cap_level = row_s[cap_row];

  // Derived only from registered column_index and cap_col, so it moves solely after clock edges
  always_comb begin
    case (state)
      SEEK:             key_pressed = (column_index == cap_col);
      DEBOUNCE, PRESSED: key_pressed = 1'b1;
      default:          key_pressed = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_row    <= '0;
      cap_col    <= '0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_row) begin
            cap_row    <= row_idx;
            cap_col    <= col_d2;
            settle_cnt <= '0;
            state      <= SEEK;
          end
        end
        SEEK: begin
          if (settle_cnt == SW'(SETTLE_CYCLES)) begin
            deb_cnt <= '0;
            state   <= DEBOUNCE;
          end else if (column_index == cap_col) begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (!cap_level) begin
            state <= IDLE;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_code  <= {cap_row, cap_col};
            key_valid <= 1'b1;
            rel_cnt   <= '0;
            state     <= PRESSED;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          // Other rows are ignored here: only the captured row can end the press
          if (cap_level) begin
            rel_cnt <= '0;
          end else if (rel_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            rel_cnt <= rel_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_row_decoder.sv
// tb/tb_keypad_row_decoder.sv - scanner + 4x4 keypad model around keypad_row_decoder with scoreboard
module tb_keypad_row_decoder;

  logic        slow_clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [1:0]  column_index;
  logic [3:0]  col_drive;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] keys;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_q[$];
  logic [3:0]  hold_exp = 4'h0;

  keypad_row_decoder dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .row_in       (row_in),
    .column_index (column_index),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .key_valid    (key_valid)
  );

  always #5 slow_clk = ~slow_clk;

  // Column scanner: free-runs unless the decoder holds it
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) column_index <= 2'd0;
    else if (!key_pressed) column_index <= column_index + 2'd1;
  end
  assign col_drive = 4'b0001 << column_index;

  // Keypad: a closed switch at (r,c) connects column c to row r
  always_comb begin
    row_in = 4'b0000;
    for (int r = 0; r < 4; r++) row_in[r] = keys[r*4 + int'(column_index)];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge slow_clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation; key_code holds otherwise
  always @(negedge slow_clk) begin
    if (!rst) begin
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {28'd0, key_code}, 32'hFFFF_FFFF);
        end else begin
          hold_exp = 4'(exp_q.pop_front());
          check("key_code", {28'd0, key_code}, {28'd0, hold_exp});
        end
      end else begin
        check("key_code_hold", {28'd0, key_code}, {28'd0, hold_exp});
      end
    end
  end

  function automatic int expect_code(input int col, input logic [3:0] row_mask);
    for (int r = 0; r < 4; r++)
      if (row_mask[r]) return r*4 + col;
    return -1;
  endfunction

  task automatic press_release(input int code, input int hold_c, input int gap_c);
    exp_q.push_back(code);
    keys[code] = 1'b1;
    tick(hold_c);
    keys[code] = 1'b0;
    tick(gap_c);
    check("strobe_arrived", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, lat, strobes, drops, w, c;
    logic [1:0] col_snap;

    keys = '0;
    rst  = 1'b1;
    #3;
    check("rst_key_pressed", key_pressed, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge slow_clk);
      check("scan_rotate", col_drive, 32'(4'b0001 << (i % 4)));
    end
    tick(3);

    // Clean press of row 2 / col 1 with latency measurement
    exp_q.push_back(9);
    keys[9] = 1'b1;
    first = -1; lat = -1; strobes = 0;
    for (c = 0; c < 30; c++) begin
      @(negedge slow_clk);
      if (first < 0 && row_in != 4'b0000) first = c;
      if (key_valid) begin strobes++; if (lat < 0) lat = c - first; end
    end
    check("press_lock_col", column_index, 1);
    check("press_one_strobe", strobes, 1);
    check("latency_le_17", (lat >= 0 && lat <= 17), 1);

    // Release with a 3-cycle re-contact glitch
    #1;
    keys[9] = 1'b0;
    drops = 0;
    for (int i = 0; i < 5; i++) begin tick(1); if (!key_pressed) drops++; end
    keys[9] = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); if (!key_pressed) drops++; end
    keys[9] = 1'b0;
    for (int i = 0; i < 9; i++) begin tick(1); if (!key_pressed) drops++; end
    check("release_held", drops, 0);
    check("release_col_held", column_index, 1);
    for (w = 0; w < 20 && key_pressed; w++) tick(1);
    check("release_done", key_pressed, 0);
    col_snap = column_index;
    tick(2);
    check("scan_resumes", (column_index != col_snap), 1);
    tick(10);

    // Bounce on row 0 / col 3, then stable
    exp_q.push_back(3);
    keys[3] = 1'b1; tick(4);
    keys[3] = 1'b0; tick(1);
    keys[3] = 1'b1; tick(30);
    keys[3] = 1'b0; tick(20);
    check("bounce_one_strobe", exp_q.size(), 0);

    // Rows 1 and 3 in column 2 together: lower row wins
    exp_q.push_back(expect_code(2, 4'b1010));
    keys[6] = 1'b1; keys[14] = 1'b1; tick(30);
    keys[6] = 1'b0; keys[14] = 1'b0; tick(20);
    check("two_key_strobe", exp_q.size(), 0);

    press_release(0, 30, 20);
    press_release(5, 30, 20);
    press_release(10, 30, 20);
    press_release(15, 30, 20);

    // Reset while debouncing row 1 / col 0
    exp_q.push_back(4);
    keys[4] = 1'b1;
    for (w = 0; w < 12 && !key_pressed; w++) tick(1);
    check("seek_lock", key_pressed, 1);
    tick(8);
    #2;
    rst = 1'b1;
    hold_exp = 4'h0;
    #1;
    check("mid_rst_key_pressed", key_pressed, 0);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_code", key_code, 0);
    check("mid_rst_no_strobe", exp_q.size(), 1);
    @(posedge slow_clk); #1;
    rst = 1'b0;
    tick(30);
    keys[4] = 1'b0;
    tick(20);
    check("redetect_strobe", exp_q.size(), 0);

    // Randomised presses (single column, random row sets) and sub-debounce bounces
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 15);
        keys[k] = 1'b1; tick($urandom_range(1, 4));
        keys[k] = 1'b0; tick(25);
        check("rand_bounce_silent", exp_q.size(), 0);
      end else begin
        int col;
        logic [3:0] mask;
        col  = $urandom_range(0, 3);
        mask = 4'($urandom_range(1, 15));
        exp_q.push_back(expect_code(col, mask));
        for (int r = 0; r < 4; r++) keys[r*4 + col] = mask[r];
        tick($urandom_range(25, 40));
        keys = '0;
        tick($urandom_range(18, 30));
        check("rand_strobe", exp_q.size(), 0);
      end
    end

    for (w = 0; w < 50 && exp_q.size() != 0; w++) tick(1);
    while (exp_q.size() != 0) begin
      check("missing_strobe", 32'(exp_q.pop_front()), 32'hFFFF_FFFF);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
